// File: rtl/for_input.sv
// Input-side scatter: buffers two data sets and dispatches their rows to the multiplier groups that request them.
// Build option FOR_INPUT_ZERO_MASK_EN zeroes every mul_din slice that carries no granted row.
module for_input #(
    parameter int DATA_WIDTH     = 4,
    parameter int KERNEL_SIZE    = 9,
    parameter int NUM_OF_MUL     = 14,
    parameter int DATA_OF_SET    = 128,
    parameter int OUT_NUM_OF_SET = 3
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic [DATA_OF_SET-1:0][DATA_WIDTH-1:0]              din,
    input  logic                                                din_valid,
    output logic                                                din_ready,
    input  logic [OUT_NUM_OF_SET-1:0]                           mul_req,
    output logic [OUT_NUM_OF_SET-1:0]                           mul_valid,
    output logic [NUM_OF_MUL*OUT_NUM_OF_SET-1:0][DATA_WIDTH-1:0] mul_din,
    output logic [OUT_NUM_OF_SET-1:0][$clog2(KERNEL_SIZE)-1:0]  mul_row,
    output logic                                                set_done
);

    localparam int ROW_W = $clog2(KERNEL_SIZE);
    localparam int USED  = KERNEL_SIZE * NUM_OF_MUL;

    typedef logic [NUM_OF_MUL-1:0][DATA_WIDTH-1:0] row_t;
    typedef row_t [KERNEL_SIZE-1:0]                 slot_t;

    slot_t [1:0]                          buf_q;
    logic                                 wr_ptr;
    logic                                 rd_ptr;
    logic [1:0]                           count;
    logic [ROW_W-1:0]                     idx;

    logic                                 accept;
    logic [OUT_NUM_OF_SET-1:0]            grant;
    logic [OUT_NUM_OF_SET-1:0][ROW_W-1:0] grant_row;
    logic                                 last;
    logic [ROW_W-1:0]                     idx_nxt;

    // Lanes past the last full row are never stored.
    logic unused_lanes;
    assign unused_lanes = ^din[DATA_OF_SET-1:USED];

    assign din_ready = !rst && (count < 2'd2);
    assign accept    = din_valid && din_ready;

    // Requesting groups take consecutive rows from idx; a set's tail never borrows rows from the next slot.
    always_comb begin
        int unsigned rank;
        int unsigned row;
        grant     = '0;
        grant_row = '0;
        last      = 1'b0;
        rank      = 0;
        row       = 0;
        if (count != 2'd0) begin
            for (int unsigned g = 0; g < OUT_NUM_OF_SET; g++) begin
                if (mul_req[g]) begin
                    row = 32'(idx) + rank;
                    if (row < KERNEL_SIZE) begin
                        grant[g]     = 1'b1;
                        grant_row[g] = ROW_W'(row);
                        if (row == KERNEL_SIZE - 1) last = 1'b1;
                    end
                    rank = rank + 1;
                end
            end
        end
        if (last || (rank == 0)) idx_nxt = last ? '0 : idx;
        else                     idx_nxt = ROW_W'(32'(idx) + rank);
    end

    always_ff @(posedge clk) begin
        if (accept) buf_q[wr_ptr] <= din[USED-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            idx       <= '0;
            mul_valid <= '0;
            mul_row   <= '0;
            mul_din   <= '0;
            set_done  <= 1'b0;
        end else begin
            if (accept) wr_ptr <= ~wr_ptr;
            if (last)   rd_ptr <= ~rd_ptr;
            idx <= idx_nxt;
            case ({accept, last})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            mul_valid <= grant;
            set_done  <= last;
            for (int unsigned g = 0; g < OUT_NUM_OF_SET; g++) begin
                if (grant[g]) begin
                    mul_row[g]                        <= grant_row[g];
                    mul_din[g*NUM_OF_MUL +: NUM_OF_MUL] <= buf_q[rd_ptr][grant_row[g]];
                end
`ifdef FOR_INPUT_ZERO_MASK_EN
                else begin
                    mul_din[g*NUM_OF_MUL +: NUM_OF_MUL] <= '0;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_for_input.sv
// Directed bench for for_input: expected per-cycle outputs are queued as stimulus is driven and checked after each edge.
module tb_for_input;

`ifdef FOR_INPUT_ZERO_MASK_EN
    localparam bit MASK = 1'b1;
`else
    localparam bit MASK = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst;
    logic [127:0][3:0]      din;
    logic                   din_valid;
    logic                   din_ready;
    logic [2:0]             mul_req;
    logic [2:0]             mul_valid;
    logic [41:0][3:0]       mul_din;
    logic [2:0][3:0]        mul_row;
    logic                   set_done;

    for_input #(
        .DATA_WIDTH(4), .KERNEL_SIZE(9), .NUM_OF_MUL(14),
        .DATA_OF_SET(128), .OUT_NUM_OF_SET(3)
    ) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .mul_req(mul_req), .mul_valid(mul_valid), .mul_din(mul_din),
        .mul_row(mul_row), .set_done(set_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        bit         rst;
        logic [2:0] v;
        int         r0, r1, r2;
        logic       d;
        int         s;
    } exp_t;

    exp_t        sb[$];
    int          compared   = 0;
    int          mismatched = 0;
    logic [3:0]  last_row[3];
    logic [55:0] last_data[3];

    // Discarded lanes 126/127 carry 15, a value no stored lane ever takes.
    function automatic logic [3:0] lane_val(int s, int lane);
        if (lane >= 126) return 4'd15;
        return 4'((lane / 14 + s * 7 + (lane % 14) * s) % 15);
    endfunction

    function automatic logic [55:0] row_data(int s, int r);
        logic [55:0] x;
        x = '0;
        for (int j = 0; j < 14; j++) x[j*4 +: 4] = lane_val(s, r * 14 + j);
        return x;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(string tag, bit r, bit v, int s, logic [2:0] req, bit er,
                       logic [2:0] ev, int r0, int r1, int r2, bit ed, int es);
        exp_t e;
        exp_t o;
        int   rows[3];
        logic [55:0] xd;
        rst       = r;
        din_valid = v;
        for (int i = 0; i < 128; i++) din[i] = lane_val(s, i);
        mul_req   = req;
        #1;
        chk({tag, "/din_ready"}, 64'(din_ready), 64'(er));
        e.tag = tag; e.rst = r; e.v = ev; e.r0 = r0; e.r1 = r1; e.r2 = r2; e.d = ed; e.s = es;
        sb.push_back(e);
        @(posedge clk);
        #1;
        o = sb.pop_front();
        if (o.rst) begin
            for (int g = 0; g < 3; g++) begin
                last_row[g]  = '0;
                last_data[g] = '0;
            end
        end
        chk({o.tag, "/mul_valid"}, 64'(mul_valid), 64'(o.v));
        chk({o.tag, "/set_done"},  64'(set_done),  64'(o.d));
        rows[0] = o.r0; rows[1] = o.r1; rows[2] = o.r2;
        for (int g = 0; g < 3; g++) begin
            if (o.v[g]) begin
                last_row[g]  = 4'(rows[g]);
                last_data[g] = row_data(o.s, rows[g]);
                xd = last_data[g];
            end else begin
                xd = MASK ? 56'd0 : last_data[g];
            end
            chk($sformatf("%s/mul_row%0d", o.tag, g), 64'(mul_row[g]), 64'(last_row[g]));
            chk($sformatf("%s/mul_din%0d", o.tag, g), 64'(mul_din[g*14 +: 14]), 64'(xd));
        end
    endtask

    initial begin
        rst = 1'b1; din_valid = 1'b0; mul_req = '0; din = '0;
        for (int g = 0; g < 3; g++) begin
            last_row[g] = '0; last_data[g] = '0;
        end
        // reset; din_valid during reset must not be taken
        cyc("rst0", 1, 0, 0, 3'b000, 0, 3'b000, 0, 0, 0, 0, 0);
        cyc("rst1", 1, 1, 0, 3'b000, 0, 3'b000, 0, 0, 0, 0, 0);
        // full-rate dispatch, set 0 lane value = row number
        cyc("s1_load", 0, 1, 0, 3'b000, 1, 3'b000, 0, 0, 0, 0, 0);
        cyc("s1_a",    0, 0, 0, 3'b111, 1, 3'b111, 0, 1, 2, 0, 0);
        cyc("s1_b",    0, 0, 0, 3'b111, 1, 3'b111, 3, 4, 5, 0, 0);
        cyc("s1_c",    0, 0, 0, 3'b111, 1, 3'b111, 6, 7, 8, 1, 0);
        cyc("s1_idle", 0, 0, 0, 3'b111, 1, 3'b000, 0, 0, 0, 0, 0);
        // sparse requests on groups 0 and 2
        cyc("s2_load", 0, 1, 1, 3'b000, 1, 3'b000, 0, 0, 0, 0, 0);
        cyc("s2_0",    0, 0, 1, 3'b101, 1, 3'b101, 0, 0, 1, 0, 1);
        cyc("s2_1",    0, 0, 1, 3'b101, 1, 3'b101, 2, 0, 3, 0, 1);
        cyc("s2_2",    0, 0, 1, 3'b101, 1, 3'b101, 4, 0, 5, 0, 1);
        cyc("s2_3",    0, 0, 1, 3'b101, 1, 3'b101, 6, 0, 7, 0, 1);
        cyc("s2_4",    0, 0, 1, 3'b101, 1, 3'b001, 8, 0, 0, 1, 1);
        // tail with both slots full does not span into the next set
        cyc("s3_ld2",  0, 1, 2, 3'b000, 1, 3'b000, 0, 0, 0, 0, 0);
        cyc("s3_ld3",  0, 1, 3, 3'b000, 1, 3'b000, 0, 0, 0, 0, 0);
        cyc("s3_a",    0, 0, 3, 3'b111, 0, 3'b111, 0, 1, 2, 0, 2);
        cyc("s3_b",    0, 0, 3, 3'b111, 0, 3'b111, 3, 4, 5, 0, 2);
        cyc("s3_c",    0, 0, 3, 3'b011, 0, 3'b011, 6, 7, 0, 0, 2);
        cyc("s3_tail", 0, 0, 3, 3'b111, 0, 3'b001, 8, 0, 0, 1, 2);
        cyc("s3_next", 0, 0, 3, 3'b111, 1, 3'b111, 0, 1, 2, 0, 3);
        cyc("s3_d",    0, 0, 3, 3'b111, 1, 3'b111, 3, 4, 5, 0, 3);
        cyc("s3_e",    0, 0, 3, 3'b111, 1, 3'b111, 6, 7, 8, 1, 3);
        // backpressure: A=4, B=5, C=6 offered back to back
        cyc("s4_A",    0, 1, 4, 3'b000, 1, 3'b000, 0, 0, 0, 0, 0);
        cyc("s4_B",    0, 1, 5, 3'b000, 1, 3'b000, 0, 0, 0, 0, 0);
        cyc("s4_C0",   0, 1, 6, 3'b000, 0, 3'b000, 0, 0, 0, 0, 0);
        cyc("s4_C1",   0, 1, 6, 3'b000, 0, 3'b000, 0, 0, 0, 0, 0);
        cyc("s4_a0",   0, 1, 6, 3'b111, 0, 3'b111, 0, 1, 2, 0, 4);
        cyc("s4_a1",   0, 1, 6, 3'b111, 0, 3'b111, 3, 4, 5, 0, 4);
        cyc("s4_a2",   0, 1, 6, 3'b111, 0, 3'b111, 6, 7, 8, 1, 4);
        cyc("s4_acc",  0, 1, 6, 3'b111, 1, 3'b111, 0, 1, 2, 0, 5);
        cyc("s4_b1",   0, 0, 6, 3'b111, 0, 3'b111, 3, 4, 5, 0, 5);
        cyc("s4_b2",   0, 0, 6, 3'b111, 0, 3'b111, 6, 7, 8, 1, 5);
        cyc("s4_c0",   0, 0, 6, 3'b111, 1, 3'b111, 0, 1, 2, 0, 6);
        cyc("s4_c1",   0, 0, 6, 3'b111, 1, 3'b111, 3, 4, 5, 0, 6);
        cyc("s4_c2",   0, 0, 6, 3'b111, 1, 3'b111, 6, 7, 8, 1, 6);
        // reset after four rows of set 7
        cyc("s5_ld",   0, 1, 7, 3'b000, 1, 3'b000, 0, 0, 0, 0, 0);
        cyc("s5_a",    0, 0, 7, 3'b111, 1, 3'b111, 0, 1, 2, 0, 7);
        cyc("s5_b",    0, 0, 7, 3'b001, 1, 3'b001, 3, 0, 0, 0, 7);
        cyc("s5_rst",  1, 0, 7, 3'b111, 0, 3'b000, 0, 0, 0, 0, 0);
        cyc("s5_post", 0, 0, 7, 3'b111, 1, 3'b000, 0, 0, 0, 0, 0);
        cyc("s5_ld2",  0, 1, 8, 3'b000, 1, 3'b000, 0, 0, 0, 0, 0);
        cyc("s5_n0",   0, 0, 8, 3'b111, 1, 3'b111, 0, 1, 2, 0, 8);
        cyc("s5_n1",   0, 0, 8, 3'b111, 1, 3'b111, 3, 4, 5, 0, 8);
        cyc("s5_n2",   0, 0, 8, 3'b111, 1, 3'b111, 6, 7, 8, 1, 8);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/for_input.md
# for_input

Input-side scatter for the convolution accelerator. It accepts one DATA_OF_SET-lane data set per handshake, splits the set into KERNEL_SIZE rows of NUM_OF_MUL lanes, and hands rows to up to OUT_NUM_OF_SET multiplier groups per cycle as each group requests. It is the counterpart of the output gather: rows leave here in ascending row order, and each row carries its row tag so the gather side can reassemble the set.

## Interface
- DATA_WIDTH, 4, bits per lane
- KERNEL_SIZE, 9, rows per set
- NUM_OF_MUL, 14, lanes per row, one per multiplier
- DATA_OF_SET, 128, lanes per input set; lanes at index KERNEL_SIZE*NUM_OF_MUL and above (126, 127) are discarded
- OUT_NUM_OF_SET, 3, number of multiplier groups
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- din  in  [DATA_OF_SET][DATA_WIDTH]  input set; row r is lanes r*NUM_OF_MUL .. r*NUM_OF_MUL+NUM_OF_MUL-1
- din_valid  in  1  din holds a set
- din_ready  out  1  a buffer slot is free
- mul_req  in  [OUT_NUM_OF_SET]  group g requests one row this cycle
- mul_valid  out  [OUT_NUM_OF_SET]  group g's slice of mul_din holds a granted row
- mul_din  out  [NUM_OF_MUL*OUT_NUM_OF_SET][DATA_WIDTH]  group g's row is at slice g*NUM_OF_MUL upward
- mul_row  out  [OUT_NUM_OF_SET][$clog2(KERNEL_SIZE)]  row index delivered to group g
- set_done  out  1  pulse; the last row of a set is on the outputs this cycle

## Operation
- Two-slot ping-pong buffer with state wr_ptr, rd_ptr, count (0..2), and row pointer idx (0..KERNEL_SIZE-1).
- din_ready = (count < 2). Accept when din_valid && din_ready: store lanes 0..125 into slot wr_ptr and toggle wr_ptr.
- Grant, evaluated each cycle only when count > 0:
  - Requesting groups are ranked k = 0, 1, 2 by ascending group index.
  - The group of rank k is granted row idx+k only if idx+k < KERNEL_SIZE.
  - Ungranted requests are dropped, not queued.
  - When count == 0, all requests are dropped.
- Grants never span sets. A tail cycle issues only the remaining rows, even when the next slot is full.
- After grants, idx advances by the number of grants.
- When row KERNEL_SIZE-1 is granted:
  - idx returns to 0.
  - rd_ptr toggles.
  - The slot is freed.
- Simultaneous accept and free leave count unchanged.
- Row-to-group mapping example with mul_req=101 and idx=4: group 0 gets row 4, group 2 gets row 5.

## Timing
- Latency is 1 cycle. A grant at the edge ending cycle t produces the following in cycle t+1:
  - mul_valid[g] = 1
  - the mul_din slice for group g holds the granted row
  - mul_row[g] holds the granted row index
- mul_valid is high for exactly one cycle per grant.
- set_done is registered and asserted in the same cycle as the mul_valid that carries row KERNEL_SIZE-1.
- din_ready rises in the cycle after the edge on which the final row is granted.
- Data accepted at edge t is grantable in cycle t+1, so the first mul_valid appears at t+2.
- Reset, checked at the clock edge:
  - count = 0, wr_ptr = 0, rd_ptr = 0, idx = 0
  - mul_valid = 0, mul_row = 0, mul_din = 0, set_done = 0
  - din_ready = 0 while rst is high, and 1 in the first cycle after rst falls
- Reset mid-set discards both slots and any partially dispatched set. No mul_valid is issued in the cycle after reset.

## Configuration
- FOR_INPUT_ZERO_MASK_EN defined: every mul_din slice whose mul_valid is 0 is driven to all zeros.
- FOR_INPUT_ZERO_MASK_EN undefined: each slice holds its last granted row until the next grant to that group.
- mul_valid, mul_row, set_done and all timing are identical in both builds.

## Test plan
- Full-rate dispatch: one set with lane value = row number, then mul_req=111 held.
  - mul_valid=111 for 3 cycles, with mul_row values (0,1,2), (3,4,5), (6,7,8).
  - set_done coincides with the third of these cycles.
  - The values of lanes 126 and 127 never appear on any output.
- Sparse requests: mul_req=101 held for one set.
  - Rows are issued as pairs (0,1), (2,3), (4,5), (6,7) on groups 0 and 2.
  - The fifth cycle has mul_valid=001, row 8, and set_done=1.
- Tail, no span: both slots full, idx=8, mul_req=111.
  - Only group 0 is granted (row 8).
  - The next cycle with mul_req=111 grants rows 0, 1, 2 of the second set.
- Backpressure: mul_req=000, with din_valid held for 3 sets.
  - Two sets are accepted, then din_ready=0.
  - Completing set A raises din_ready one cycle after its final grant.
  - Accepting set C in that cycle, while granting from set B, keeps count at 2.
- Reset mid-set: assert rst after 4 rows are granted.
  - All outputs read 0 in the cycle after rst.
  - A new set then dispatches from row 0.
- Macro: run scenario 2 in both builds. Group 1's slice reads 0 with FOR_INPUT_ZERO_MASK_EN, and the idle groups' slices hold their previous rows without it.
